// File: rtl/reduce_adder_pkg.sv
// Shared helpers for the pipelined reduction adder: tree depth, stage control record,
// lane-extension mode codes and saturation bounds.
package reduce_adder_pkg;

   // Lane extension modes selected by the SIGNED parameter.
   localparam int EXT_ZERO = 0;
   localparam int EXT_SIGN = 1;

   // Control half of a tree stage record; the partial sums travel beside it,
   // because their width depends on the level.
   typedef struct packed {
      logic valid;
      logic last;
   } stage_ctl_t;

   // Number of tree levels. Non-power-of-two lane counts round up and are padded with zero lanes.
   function automatic int clog2_pad(input int n);
      int l;
      l = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << l) < n) l++;
      end
      return l;
   endfunction

   // Largest value that fits in w bits, for unsigned or two's-complement data.
   function automatic logic [63:0] sat_max(input bit is_signed, input int w);
      logic [63:0] m;
      m = '1;
      m = m >> (64 - w);
      if (is_signed) m = m >> 1;
      return m;
   endfunction

   // Smallest value that fits in w bits, for unsigned or two's-complement data.
   function automatic logic [63:0] sat_min(input bit is_signed, input int w);
      return is_signed ? (64'd1 << (w - 1)) : 64'd0;
   endfunction

endpackage

// File: rtl/reduce_adder_stage.sv
// One registered level of the reduction tree: it adds PAIRS pairs of partial sums and
// carries a valid/last slice that collapses bubbles.
module reduce_adder_stage
   import reduce_adder_pkg::*;
#(
   parameter int PAIRS = 1,
   parameter int W     = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 up_valid,
   input  logic                 up_last,
   input  logic [2*PAIRS*W-1:0] up_sums,
   output logic                 up_ready,
   output logic                 dn_valid,
   output logic                 dn_last,
   output logic [PAIRS*W-1:0]   dn_sums,
   input  logic                 dn_ready
);

   stage_ctl_t           ctl_q;
   logic [PAIRS*W-1:0]   sums_q;
   logic [PAIRS*W-1:0]   sums_d;

   // The stage loads when it is empty or when the level below takes its contents.
   // up_ready never depends on up_valid.
   assign up_ready = !ctl_q.valid || dn_ready;

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      sums_d = '0;
      for (int p = 0; p < PAIRS; p++) begin
         sums_d[p*W +: W] = up_sums[2*p*W +: W] + up_sums[(2*p+1)*W +: W];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_q  <= '0;
         sums_q <= '0;
      end else if (up_ready) begin
         ctl_q.valid <= up_valid;
         ctl_q.last  <= up_valid && up_last;
         if (up_valid) sums_q <= sums_d;
      end
   end

   assign dn_valid = ctl_q.valid;
   assign dn_last  = ctl_q.last;
   assign dn_sums  = sums_q;

endmodule

// File: rtl/reduce_adder_pipe.sv
// Pipelined NUM-lane reduction adder with packet accumulation and valid/ready backpressure.
// Define REDUCE_ADDER_PIPE_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module reduce_adder_pipe
   import reduce_adder_pkg::*;
#(
   parameter int BITS     = 8,
   parameter int NUM      = 16,
   parameter int OUT_BITS = BITS + $clog2(NUM),
   parameter int SIGNED   = 0,
   parameter int CNT_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_last,
   input  logic [NUM*BITS-1:0]  data_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_BITS-1:0]  out_sum,
   output logic [CNT_BITS-1:0]  out_beats,
   output logic                 out_ovf
);

   localparam int L   = clog2_pad(NUM);
   localparam int P   = 1 << L;
   localparam int MSB = OUT_BITS - 1;

   // All tree levels packed end to end: level k starts at sum index 2P - 2^(L-k+1).
   logic [(2*P-1)*OUT_BITS-1:0] tree_bus;
   logic [L:0]                  lv_valid;
   logic [L:0]                  lv_last;
   logic [L:0]                  lv_ready;

   for (genvar i = 0; i < P; i++) begin : g_lane
      if (i < NUM) begin : g_real
         logic [BITS-1:0] lane;
         logic            ext_bit;
         assign lane    = data_in[i*BITS +: BITS];
         assign ext_bit = (SIGNED == EXT_SIGN) ? lane[BITS-1] : 1'b0;
         assign tree_bus[i*OUT_BITS +: OUT_BITS] = {{(OUT_BITS-BITS){ext_bit}}, lane};
      end else begin : g_pad
         assign tree_bus[i*OUT_BITS +: OUT_BITS] = '0;
      end
   end

   assign lv_valid[0] = in_valid;
   assign lv_last[0]  = in_last;
   assign in_ready    = lv_ready[0];

   for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int PAIRS   = 1 << (L - k - 1);
      localparam int IN_OFF  = (1 << (L + 1)) - (1 << (L - k + 1));
      localparam int OUT_OFF = (1 << (L + 1)) - (1 << (L - k));

      reduce_adder_stage #(
         .PAIRS (PAIRS),
         .W     (OUT_BITS)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .up_valid (lv_valid[k]),
         .up_last  (lv_last[k]),
         .up_sums  (tree_bus[IN_OFF*OUT_BITS +: 2*PAIRS*OUT_BITS]),
         .up_ready (lv_ready[k]),
         .dn_valid (lv_valid[k+1]),
         .dn_last  (lv_last[k+1]),
         .dn_sums  (tree_bus[OUT_OFF*OUT_BITS +: PAIRS*OUT_BITS]),
         .dn_ready (lv_ready[k+1])
      );
   end

   logic                t_valid;
   logic                t_last;
   logic [OUT_BITS-1:0] t_sum;
   logic                out_free;
   logic                acc_ready;
   logic                take;

   logic [OUT_BITS-1:0] acc_q;
   logic                first_q;
   logic [CNT_BITS-1:0] cnt_q;
   logic                ovf_q;

   logic [OUT_BITS-1:0] base;
   logic [OUT_BITS:0]   raw;
   logic                ovf_now;
   logic [OUT_BITS-1:0] sum_d;
   logic [CNT_BITS-1:0] cnt_inc;

   assign t_valid = lv_valid[L];
   assign t_last  = lv_last[L];
   assign t_sum   = tree_bus[(2*P-2)*OUT_BITS +: OUT_BITS];

   // Non-last beats are always absorbed; a closing beat waits for room in the output register.
   assign out_free    = !out_valid || out_ready;
   assign acc_ready   = !t_last || out_free;
   assign take        = t_valid && acc_ready;
   assign lv_ready[L] = acc_ready;

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef REDUCE_ADDER_PIPE_SAT_EN
   localparam logic [63:0]         SAT_MAX_W = sat_max(SIGNED == EXT_SIGN, OUT_BITS);
   localparam logic [63:0]         SAT_MIN_W = sat_min(SIGNED == EXT_SIGN, OUT_BITS);
   localparam logic [OUT_BITS-1:0] SAT_MAX   = SAT_MAX_W[OUT_BITS-1:0];
   localparam logic [OUT_BITS-1:0] SAT_MIN   = SAT_MIN_W[OUT_BITS-1:0];
`endif

   always_comb begin
      base = first_q ? '0 : acc_q;
      raw  = {1'b0, base} + {1'b0, t_sum};
      if (SIGNED == EXT_SIGN) ovf_now = (base[MSB] == t_sum[MSB]) && (raw[MSB] != base[MSB]);
      else                    ovf_now = raw[OUT_BITS];
`ifdef REDUCE_ADDER_PIPE_SAT_EN
      // Once clamped, the accumulator holds its bound until the packet closes.
      if (ovf_q)        sum_d = acc_q;
      else if (ovf_now) sum_d = ((SIGNED == EXT_SIGN) && base[MSB]) ? SAT_MIN : SAT_MAX;
      else              sum_d = raw[OUT_BITS-1:0];
`else
      sum_d = raw[OUT_BITS-1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         first_q   <= 1'b1;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_beats <= '0;
         out_ovf   <= 1'b0;
      end else begin
         if (take) begin
            if (t_last) begin
               out_sum   <= sum_d;
               out_beats <= cnt_inc;
               out_ovf   <= ovf_q || ovf_now;
               acc_q     <= '0;
               first_q   <= 1'b1;
               cnt_q     <= '0;
               ovf_q     <= 1'b0;
            end else begin
               acc_q     <= sum_d;
               cnt_q     <= cnt_inc;
               first_q   <= 1'b0;
               ovf_q     <= ovf_q || ovf_now;
            end
         end
         if (take && t_last) out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reduce_adder_pipe.sv
// Scoreboard bench for reduce_adder_pipe: an unsigned and a signed instance, directed packets,
// output stall, and reset in the middle of a packet.
module tb_reduce_adder_pipe;

   localparam int NUM = 16;

   typedef struct {
      logic [11:0] sum;
      logic [7:0]  beats;
      logic        ovf;
      int          lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_last = 1'b0;
   logic [127:0] data_in = '0;

   logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_ovf;
   logic [11:0]  out_sum;
   logic [7:0]   out_beats;

   logic         s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1, s_out_ovf;
   logic [11:0]  s_out_sum;
   logic [7:0]   s_out_beats;

   int           total = 0;
   int           bad = 0;
   int           edge_cnt = 0;
   int           accept_cnt = 0;
   int           stall_at = -1;
   exp_t         q_u[$];
   exp_t         q_s[$];
   int           hs_u[$];
   logic [127:0] pat[$];

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   reduce_adder_pipe #(.BITS(8), .NUM(NUM), .OUT_BITS(12), .SIGNED(0), .CNT_BITS(8)) dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_beats(out_beats), .out_ovf(out_ovf));

   reduce_adder_pipe #(.BITS(8), .NUM(NUM), .OUT_BITS(12), .SIGNED(1), .CNT_BITS(8)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_last(in_last),
      .data_in(data_in), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum),
      .out_beats(s_out_beats), .out_ovf(s_out_ovf));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic [127:0] fill(input logic [7:0] v);
      logic [127:0] r;
      for (int i = 0; i < NUM; i++) r[i*8 +: 8] = v;
      return r;
   endfunction

   function automatic logic [127:0] alt(input logic [7:0] a, input logic [7:0] b);
      logic [127:0] r;
      for (int i = 0; i < NUM; i++) r[i*8 +: 8] = (i % 2 == 0) ? a : b;
      return r;
   endfunction

   function automatic logic [127:0] ramp();
      logic [127:0] r;
      for (int i = 0; i < NUM; i++) r[i*8 +: 8] = 8'(i);
      return r;
   endfunction

   // Monitors: pop and compare on every output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #1;
         if (rst_n && out_valid && out_ready) begin
            hs_u.push_back(edge_cnt);
            if (q_u.size() == 0) begin
               total++; bad++;
               $display("FAIL u_extra: got sum=%0h beats=%0d, required no result", out_sum, out_beats);
            end else begin
               e = q_u.pop_front();
               check("u_sum", 32'(out_sum), 32'(e.sum));
               check("u_beats", 32'(out_beats), 32'(e.beats));
               check("u_ovf", 32'(out_ovf), 32'(e.ovf));
               if (e.lat >= 0) check("u_latency", 32'(edge_cnt - e.lat), 32'd5);
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #1;
         if (rst_n && s_out_valid && s_out_ready) begin
            if (q_s.size() == 0) begin
               total++; bad++;
               $display("FAIL s_extra: got sum=%0h beats=%0d, required no result", s_out_sum, s_out_beats);
            end else begin
               e = q_s.pop_front();
               check("s_sum", 32'(s_out_sum), 32'(e.sum));
               check("s_beats", 32'(s_out_beats), 32'(e.beats));
               check("s_ovf", 32'(s_out_ovf), 32'(e.ovf));
            end
         end
      end
   end

   // Drive one beat and wait (bounded) for acceptance; a is the edge count before the accepting edge.
   task automatic drive_beat(input bit sgn, input logic [127:0] d, input bit last, output int a);
      int w;
      w = 0;
      a = -1;
      @(negedge clk);
      data_in = d;
      in_last = last;
      if (sgn) s_in_valid = 1'b1; else in_valid = 1'b1;
      #1;
      while (!(sgn ? s_in_ready : in_ready) && w < 200) begin
         w++;
         @(negedge clk); #1;
      end
      if (w > 0 && stall_at < 0) stall_at = accept_cnt;
      if (w >= 200) begin
         total++; bad++;
         $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, required acceptance", w);
         in_valid = 1'b0;
         s_in_valid = 1'b0;
         return;
      end
      a = edge_cnt;
      @(posedge clk); #1;
      accept_cnt++;
      in_valid = 1'b0;
      s_in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic send_pkt(input bit sgn, input int n, input logic [11:0] esum,
                           input logic [7:0] ebeats, input bit eovf, input bit chk_lat);
      exp_t e;
      int   a;
      a = -1;
      for (int i = 0; i < n; i++) begin
         drive_beat(sgn, pat[(i < pat.size()) ? i : pat.size() - 1], i == n - 1, a);
      end
      if (a >= 0) begin
         e.sum = esum; e.beats = ebeats; e.ovf = eovf; e.lat = chk_lat ? a : -1;
         if (sgn) q_s.push_back(e); else q_u.push_back(e);
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((q_u.size() != 0 || q_s.size() != 0) && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (w >= 300) begin
         total++; bad++;
         $display("FAIL drain_timeout: got %0d/%0d pending, required 0", q_u.size(), q_s.size());
         q_u.delete();
         q_s.delete();
      end
      repeat (8) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      check("rst_out_beats", 32'(out_beats), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_s_in_ready", 32'(s_in_ready), 32'd1);

      // Single beat of 0xFF lanes with latency check
      pat.delete(); pat.push_back(fill(8'hFF));
      send_pkt(1'b0, 1, 12'hFF0, 8'd1, 1'b0, 1'b1);
      drain();

      // Three beats: lanes 1, 2, 3
      pat.delete(); pat.push_back(fill(8'd1)); pat.push_back(fill(8'd2)); pat.push_back(fill(8'd3));
      send_pkt(1'b0, 3, 12'h060, 8'd3, 1'b0, 1'b0);

      // Two beats of 0xFF: accumulator overflow
      pat.delete(); pat.push_back(fill(8'hFF));
`ifdef REDUCE_ADDER_PIPE_SAT_EN
      send_pkt(1'b0, 2, 12'hFFF, 8'd2, 1'b1, 1'b0);
`else
      send_pkt(1'b0, 2, 12'hFE0, 8'd2, 1'b1, 1'b0);
`endif

      // Lane i = i: 0+1+...+15
      pat.delete(); pat.push_back(ramp());
      send_pkt(1'b0, 1, 12'h078, 8'd1, 1'b0, 1'b0);

      // Signed lanes
      pat.delete(); pat.push_back(fill(8'h80));
      send_pkt(1'b1, 1, 12'h800, 8'd1, 1'b0, 1'b0);
      pat.delete(); pat.push_back(alt(8'h7F, 8'h81));
      send_pkt(1'b1, 1, 12'h000, 8'd1, 1'b0, 1'b0);
      pat.delete(); pat.push_back(fill(8'h80));
`ifdef REDUCE_ADDER_PIPE_SAT_EN
      send_pkt(1'b1, 2, 12'h800, 8'd2, 1'b1, 1'b0);
`else
      send_pkt(1'b1, 2, 12'h000, 8'd2, 1'b1, 1'b0);
`endif
      drain();

      // 300 beats of lanes=1: beat counter saturates, accumulator overflows at beat 256
      pat.delete(); pat.push_back(fill(8'd1));
`ifdef REDUCE_ADDER_PIPE_SAT_EN
      send_pkt(1'b0, 300, 12'hFFF, 8'd255, 1'b1, 1'b0);
`else
      send_pkt(1'b0, 300, 12'h2C0, 8'd255, 1'b1, 1'b0);
`endif
      drain();

      // Output stalled for 20 cycles under a stream of single-beat packets
      hs_u.delete();
      accept_cnt = 0;
      stall_at = -1;
      fork
         begin
            @(negedge clk);
            out_ready = 1'b0;
            repeat (20) @(negedge clk);
            out_ready = 1'b1;
         end
         begin
            for (int k = 1; k <= 8; k++) begin
               pat.delete(); pat.push_back(fill(8'(k)));
               send_pkt(1'b0, 1, 12'(16 * k), 8'd1, 1'b0, 1'b0);
            end
         end
      join
      drain();
      check("stall_fill_depth", 32'(stall_at), 32'd5);
      check("stall_results", 32'(hs_u.size()), 32'd8);
      if (hs_u.size() >= 5) begin
         for (int i = 1; i < 5; i++) check("stream_gap", 32'(hs_u[i] - hs_u[i-1]), 32'd1);
      end

      // Reset in the middle of a 4-beat packet, then a fresh single-beat packet
      begin
         int a;
         drive_beat(1'b0, fill(8'd5), 1'b0, a);
         drive_beat(1'b0, fill(8'd5), 1'b0, a);
      end
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      pat.delete(); pat.push_back(fill(8'd1));
      send_pkt(1'b0, 1, 12'd16, 8'd1, 1'b0, 1'b0);
      drain();

      check("u_queue_empty", 32'(q_u.size()), 32'd0);
      check("s_queue_empty", 32'(q_s.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
